// File: rtl/outport_arb_pkg.sv
// Shared types and constants for the output-port write arbiter.
// Holds the FSM state encoding, the highest legal port address and the requester default.
package outport_arb_pkg;

    localparam int NREQ_DEFAULT = 4;

    localparam logic [7:0] OUTPORT_MAX_ADDR = 8'h03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/outport_arbiter_rr.sv
// Combinational round-robin search: the first requester with req high,
// starting at rr_ptr and wrapping modulo NREQ.
module rr_arbiter
    import outport_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_idx
);

    // scan from rr_ptr upward, keeping the first hit
    always_comb begin
        int j;
        j           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/outport_arbiter.sv
// Arbitrates NREQ requesters onto one output-port register bank, IDLE->WRITE->DONE.
// Optional address range check: define OUTPORT_ARB_ADDRCHK_EN to reject addresses above OUTPORT_MAX_ADDR.
module outport_arbiter
    import outport_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    err,
    output logic [AW-1:0]      port_addr,
    output logic [DW-1:0]      port_data,
    output logic               port_write,
    output logic               busy
);

    localparam int IW = idx_width(NREQ);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] g_idx_q, g_idx_d;
    logic [AW-1:0] port_addr_q, port_addr_d;
    logic [DW-1:0] port_data_q, port_data_d;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          addr_bad;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req         (req),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

`ifdef OUTPORT_ARB_ADDRCHK_EN
    assign addr_bad = (port_addr_q > AW'(OUTPORT_MAX_ADDR));
`else
    assign addr_bad = 1'b0;
`endif

    // next state: capture the winner in IDLE, advance the pointer leaving DONE
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        g_idx_d     = g_idx_q;
        port_addr_d = port_addr_q;
        port_data_d = port_data_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d     = WRITE;
                    g_idx_d     = grant_idx;
                    port_addr_d = req_addr[int'(grant_idx)*AW +: AW];
                    port_data_d = req_data[int'(grant_idx)*DW +: DW];
                end
            end
            WRITE: state_d = DONE;
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = (g_idx_q == IW'(NREQ-1)) ? '0 : g_idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and captured transfer registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            g_idx_q     <= '0;
            port_addr_q <= '0;
            port_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            g_idx_q     <= g_idx_d;
            port_addr_q <= port_addr_d;
            port_data_q <= port_data_d;
        end
    end

    // completion pulses, decoded from state so reset clears them at once
    always_comb begin
        ack = '0;
        err = '0;
        if (state_q == DONE) begin
            if (addr_bad) err[g_idx_q] = 1'b1;
            else          ack[g_idx_q] = 1'b1;
        end
    end

    assign port_write = (state_q == WRITE) && !addr_bad;
    assign busy       = (state_q != IDLE);
    assign port_addr  = port_addr_q;
    assign port_data  = port_data_q;

endmodule

// File: tb/tb_outport_arbiter.sv
// Self-checking bench for outport_arbiter: vector table, hand sequences, scoreboard.
// Outputs are sampled on the falling edge; inputs change on the falling edge too.
module tb_outport_arbiter;

    localparam bit CHK =
`ifdef OUTPORT_ARB_ADDRCHK_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        Reset;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [7:0]  port_addr;
    logic [7:0]  port_data;
    logic        port_write;
    logic        busy;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    outport_arbiter #(.NREQ(4), .AW(8), .DW(8)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .ack        (ack),
        .err        (err),
        .port_addr  (port_addr),
        .port_data  (port_data),
        .port_write (port_write),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [3:0] ack;
        logic [3:0] err;
    } ae_t;

    typedef struct {
        int         idx;
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_wr;
        logic [3:0] exp_ack;
        logic [3:0] exp_err;
    } vec_t;

    wr_t wr_q[$];
    ae_t ae_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mkv(input int idx, input logic [7:0] a, input logic [7:0] d);
        vec_t v;
        logic bad;
        bad       = CHK && (a > 8'h03);
        v.idx     = idx;
        v.addr    = a;
        v.data    = d;
        v.exp_wr  = !bad;
        v.exp_ack = bad ? 4'b0 : 4'(1 << idx);
        v.exp_err = bad ? 4'(1 << idx) : 4'b0;
        return v;
    endfunction

    task automatic drive(input int idx, input logic [7:0] a, input logic [7:0] d);
        req[idx]             = 1'b1;
        req_addr[idx*8 +: 8] = a;
        req_data[idx*8 +: 8] = d;
    endtask

    task automatic expect_txn(input int idx, input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        ae_t e;
        w.a   = a;
        w.d   = d;
        e.ack = 4'(1 << idx);
        e.err = 4'b0;
        wr_q.push_back(w);
        ae_q.push_back(e);
    endtask

    // scoreboard: every write strobe and every ack/err pulse consumes one expectation
    always @(negedge clk) begin
        wr_t w;
        ae_t e;
        if (!Reset) begin
            if (port_write) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 32'(port_write), 32'(0));
                end else begin
                    w = wr_q.pop_front();
                    chk("sb_addr", 32'(port_addr), 32'(w.a));
                    chk("sb_data", 32'(port_data), 32'(w.d));
                end
            end
            if ((ack | err) != 4'b0) begin
                if (ae_q.size() == 0) begin
                    chk("ae_unexpected", 32'({ack, err}), 32'(0));
                end else begin
                    e = ae_q.pop_front();
                    chk("sb_ack", 32'(ack), 32'(e.ack));
                    chk("sb_err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        wr_t w;
        ae_t e;
        drive(v.idx, v.addr, v.data);
        w.a   = v.addr;
        w.d   = v.data;
        e.ack = v.exp_ack;
        e.err = v.exp_err;
        if (v.exp_wr) wr_q.push_back(w);
        ae_q.push_back(e);
        @(negedge clk);
        chk("v_busy1", 32'(busy), 32'(1));
        chk("v_write", 32'(port_write), 32'(v.exp_wr));
        @(negedge clk);
        chk("v_busy2", 32'(busy), 32'(1));
        chk("v_wr_off", 32'(port_write), 32'(0));
        chk("v_ack", 32'(ack), 32'(v.exp_ack));
        chk("v_err", 32'(err), 32'(v.exp_err));
        req[v.idx] = 1'b0;
        @(negedge clk);
        chk("v_idle", 32'(busy), 32'(0));
        chk("v_ack_off", 32'(ack | err), 32'(0));
        chk("v_hold", 32'({port_addr, port_data}), 32'({v.addr, v.data}));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = mkv(1, 8'h02, 8'hA5);
        vecs[1] = mkv(0, 8'h00, 8'h11);
        vecs[2] = mkv(3, 8'h03, 8'hC3);
        vecs[3] = mkv(2, 8'h01, 8'h7E);
        vecs[4] = mkv(0, 8'h07, 8'h99);
        vecs[5] = mkv(3, 8'hFF, 8'h00);

        Reset    = 1'b1;
        req      = 4'b0;
        req_addr = '0;
        req_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_write", 32'(port_write), 32'(0));
        chk("rst_ackerr", 32'({ack, err}), 32'(0));
        chk("rst_port", 32'({port_addr, port_data}), 32'(0));

        // all four requesting from reset: grants 0,1,2,3,0
        for (int i = 0; i < 4; i++) drive(i, 8'(i), 8'(8'h40 + i));
        for (int g = 0; g < 5; g++) expect_txn(g % 4, 8'(g % 4), 8'(8'h40 + (g % 4)));
        Reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("cont_wr", 32'(port_write), 32'(i % 3 == 1));
            chk("cont_ack", 32'(ack != 4'b0), 32'(i % 3 == 2));
            if (i == 14) req = 4'b0;
        end
        chk("cont_idle", 32'(busy), 32'(0));

        // table of single transfers
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // after a grant to 0, a tie between 0 and 1 goes to 1
        run_vec(mkv(0, 8'h07, 8'h5C));
        drive(0, 8'h00, 8'hE0);
        drive(1, 8'h01, 8'hE1);
        expect_txn(1, 8'h01, 8'hE1);
        expect_txn(0, 8'h00, 8'hE0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("tie_wr", 32'(port_write), 32'(i == 1 || i == 4));
            if (i == 2) req[1] = 1'b0;
            if (i == 5) req[0] = 1'b0;
        end

        // req[2] dropped in WRITE still completes; a 1-cycle req[3] while busy is ignored
        drive(2, 8'h01, 8'h33);
        expect_txn(2, 8'h01, 8'h33);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("drop_wr", 32'(port_write), 32'(1));
                req[2] = 1'b0;
                drive(3, 8'h02, 8'h66);
            end else if (i == 2) begin
                chk("drop_ack", 32'(ack), 32'(4'b0100));
                req[3] = 1'b0;
            end else begin
                chk("pulse_nowr", 32'(port_write), 32'(0));
                chk("pulse_idle", 32'(busy), 32'(0));
            end
        end

        // reset during WRITE aborts; pointer restarts at 0 so 1 beats 3
        drive(3, 8'h03, 8'h3C);
        expect_txn(3, 8'h03, 8'h3C);
        @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        chk("abort_wr", 32'(port_write), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_ack", 32'({ack, err}), 32'(0));
        ae_q.delete();
        @(negedge clk);
        drive(1, 8'h01, 8'h1D);
        expect_txn(1, 8'h01, 8'h1D);
        expect_txn(3, 8'h03, 8'h3C);
        @(negedge clk);
        Reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("rearb_wr", 32'(port_write), 32'(i == 1 || i == 4));
            if (i == 2) req[1] = 1'b0;
            if (i == 5) req[3] = 1'b0;
        end

        chk("wr_q_empty", 32'(wr_q.size()), 32'(0));
        chk("ae_q_empty", 32'(ae_q.size()), 32'(0));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
